// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM encoding, key map
// and row priority selection.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'hF;

  function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest-index active-low row wins when several rows are pressed at once.
  function automatic logic [1:0] first_low(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all-ones so idle (pulled-up) rows read inactive.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and no rollover.
// Define KEYPAD_TWO_DIGIT_EN to keep a two-key history on the digits output.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4096,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held,
  output logic [7:0] digits
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       row_s;
  state_t           state;
  logic [1:0]       c;
  logic [1:0]       r;
  logic [DIV_W-1:0] div;
  logic [DEB_W-1:0] dcnt;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (row_s)
  );

  assign col = ~(4'b0001 << c);

  // The divider only runs in SCAN; every exit happens at terminal count, so
  // it is already back at zero whenever SCAN is re-entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      c         <= 2'd0;
      r         <= 2'd0;
      div       <= '0;
      dcnt      <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (div == DIV_LAST) begin
            div <= '0;
            if (row_s != ROWS_IDLE) begin
              r     <= first_low(row_s);
              dcnt  <= '0;
              state <= DEBOUNCE;
            end else begin
              c <= c + 2'd1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_s[r]) begin
            c     <= c + 2'd1;
            state <= SCAN;
          end else if (dcnt == DEB_LAST) begin
            key       <= keymap(r, c);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        HELD: begin
          if (row_s[r]) begin
            dcnt  <= '0;
            state <= RELEASE;
          end
        end
        default: begin
          if (!row_s[r]) begin
            state <= HELD;
          end else if (dcnt == DEB_LAST) begin
            key_held <= 1'b0;
            c        <= c + 2'd1;
            state    <= SCAN;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef KEYPAD_TWO_DIGIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits <= 8'h00;
    end else if (state == DEBOUNCE && !row_s[r] && dcnt == DEB_LAST) begin
      digits <= {digits[3:0], keymap(r, c)};
    end
  end
`else
  assign digits = 8'h00;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic [7:0] digits;

  int total;
  int bad;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held),
    .digits    (digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns at the negedge where col has just switched to target.
  task automatic wait_col(input logic [3:0] target);
    int n;
    n = 0;
    while (col == target && n < 64) begin
      @(negedge clk);
      n++;
    end
    while (col != target && n < 64) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (col != target) begin
      bad++;
      $display("FAIL wait_col: col=%b never reached %b", col, target);
    end
  endtask

  task automatic press_and_count(input logic [3:0] rows, output int pulses,
                                 output int first_at, output logic [3:0] seen);
    pulses   = 0;
    first_at = -1;
    seen     = 4'hx;
    row      = rows;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (key_valid) begin
        pulses++;
        if (first_at < 0) begin
          first_at = i;
          seen     = key;
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    row = 4'hF;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [3:0] exp_col;
    reset = 1'b1;
    row   = 4'hF;
    repeat (3) @(negedge clk);
    total++;
    if (col !== 4'b1110 || key !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0 || digits !== 8'h00) begin
      bad++;
      $display("FAIL reset_values: col=%b key=%h valid=%b held=%b digits=%h want 1110/0/0/0/00",
               col, key, key_valid, key_held, digits);
    end
    reset = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      total++;
      if (col !== exp_col || key_valid !== 1'b0 || key_held !== 1'b0 || key !== 4'h0) begin
        bad++;
        $display("FAIL idle_walk[%0d]: col=%b valid=%b held=%b key=%h want col=%b 0/0/0",
                 k, col, key_valid, key_held, key, exp_col);
      end
    end
  endtask

  task automatic test_press_5;
    int pulses, at;
    logic [3:0] seen;
    wait_col(4'b1101);
    press_and_count(4'b1101, pulses, at, seen);
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL press5_pulses: got %0d want 1", pulses);
    end
    total++;
    if (seen !== 4'h5 || key !== 4'h5) begin
      bad++;
      $display("FAIL press5_key: pulse key=%h key=%h want 5", seen, key);
    end
    total++;
    if (at < 11 || at > 14) begin
      bad++;
      $display("FAIL press5_latency: pulse after %0d cycles want 11..14", at);
    end
    total++;
    if (key_held !== 1'b1 || col !== 4'b1101) begin
      bad++;
      $display("FAIL press5_held: held=%b col=%b want 1/1101", key_held, col);
    end
  endtask

  task automatic test_release_bounce;
    int pulses, falls, fall_at;
    logic prev;
    pulses  = 0;
    falls   = 0;
    fall_at = -1;
    prev    = key_held;
    for (int i = 0; i < 36; i++) begin
      row = (i >= 4 && i < 7) ? 4'b1101 : 4'hF;
      @(negedge clk);
      if (key_valid) pulses++;
      if (prev && !key_held) begin
        falls++;
        fall_at = i + 1;
      end
      prev = key_held;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL release_pulses: got %0d want 0", pulses);
    end
    total++;
    if (falls !== 1) begin
      bad++;
      $display("FAIL release_falls: got %0d want 1", falls);
    end
    total++;
    if (fall_at < 16 || fall_at > 20) begin
      bad++;
      $display("FAIL release_timing: held fell after %0d cycles want 16..20", fall_at);
    end
    total++;
    if (key !== 4'h5) begin
      bad++;
      $display("FAIL release_key_kept: key=%h want 5", key);
    end
    wait_col(4'b0111);
  endtask

  task automatic test_glitch;
    logic [3:0] col_after [0:20];
    int pulses;
    pulses = 0;
    wait_col(4'b0111);
    for (int i = 0; i < 20; i++) begin
      row = (i < 3) ? 4'b0111 : 4'hF;
      @(negedge clk);
      col_after[i+1] = col;
      if (key_valid) pulses++;
    end
    total++;
    if (pulses !== 0 || key_held !== 1'b0) begin
      bad++;
      $display("FAIL glitch_pulse: pulses=%0d held=%b want 0/0", pulses, key_held);
    end
    total++;
    if (col_after[5] !== 4'b0111) begin
      bad++;
      $display("FAIL glitch_frozen: col=%b want 0111", col_after[5]);
    end
    total++;
    if (col_after[6] !== 4'b1110) begin
      bad++;
      $display("FAIL glitch_advance: col=%b want 1110", col_after[6]);
    end
  endtask

  task automatic test_multi_row;
    int pulses, at;
    logic [3:0] seen;
    logic [7:0] exp_dig;
    wait_col(4'b1110);
    press_and_count(4'b1010, pulses, at, seen);
    total++;
    if (pulses !== 1 || seen !== 4'h1 || key !== 4'h1) begin
      bad++;
      $display("FAIL multi_row: pulses=%0d key=%h want 1 pulse key 1", pulses, seen);
    end
    idle_cycles(30);
    total++;
    if (key_held !== 1'b0) begin
      bad++;
      $display("FAIL multi_release: held=%b want 0", key_held);
    end
    wait_col(4'b1101);
    press_and_count(4'b1101, pulses, at, seen);
`ifdef KEYPAD_TWO_DIGIT_EN
    exp_dig = 8'h15;
`else
    exp_dig = 8'h00;
`endif
    total++;
    if (pulses !== 1 || seen !== 4'h5 || digits !== exp_dig) begin
      bad++;
      $display("FAIL digits: pulses=%0d key=%h digits=%h want 1/5/%h", pulses, seen, digits, exp_dig);
    end
    idle_cycles(30);
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    wait_col(4'b1011);
    row = 4'b1011;
    repeat (6) @(negedge clk);
    total++;
    if (col !== 4'b1011 || key_valid !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset_debounce: col=%b valid=%b want 1011/0", col, key_valid);
    end
    reset = 1'b1;
    #1;
    total++;
    if (col !== 4'b1110 || key !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0 || digits !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: col=%b key=%h valid=%b held=%b digits=%h want 1110/0/0/0/00",
               col, key, key_valid, key_held, digits);
    end
    row = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
    total++;
    if (pulses !== 0 || key !== 4'h0) begin
      bad++;
      $display("FAIL post_reset: pulses=%0d key=%h want 0/0", pulses, key);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    row   = 4'hF;
    test_reset;
    test_press_5;
    test_release_bounce;
    test_glitch;
    test_multi_row;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad by time-multiplexing its columns and sampling its rows.
- Sits on the input side of the board, opposite the time-multiplexed dual 7-segment display driver.
- Outputs a debounced hex key code with a one-cycle valid strobe, for the display/sum datapath.

Parameters:
- SCAN_DIV, 4096: clk cycles each column is driven before rows are sampled and the scan advances (>=4).
- DEBOUNCE_CYCLES, 65536: consecutive stable cycles required to accept a press or a release (>=2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- row  input  4  keypad rows; active-low, external pull-ups, asynchronous to clk
- col  output  4  keypad columns; active-low, exactly one low at any time
- key  output  4  hex code of last accepted key
- key_valid  output  1  one-cycle pulse when a new key is accepted
- key_held  output  1  high while the accepted key remains pressed
- digits  output  8  two-digit history: [7:4] previous key, [3:0] newest key

Behaviour:
- Reset values: col=4'b1110, key=0, key_valid=0, key_held=0, digits=0, FSM=SCAN, all counters=0.
- row passes through a 2-flop synchronizer to give row_s; the FSM only uses row_s.
- Column index c drives col = ~(1<<c).
- Priority rule: the lowest-index low bit of row_s is the detected row r.
- Keymap (r,c): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
- SCAN state:
  - Divider counts 0..SCAN_DIV-1.
  - At terminal count: if row_s != 4'hF, latch r and c, clear the debounce counter, go to DEBOUNCE (c frozen).
  - Otherwise c increments mod 4 (3 wraps to 0).
- DEBOUNCE state:
  - Each cycle row_s[r]==0 increments the counter; any cycle with row_s[r]==1 returns to SCAN, with c advancing to the next column.
  - When the counter reaches DEBOUNCE_CYCLES-1: next cycle key=keymap(r,c), key_valid=1 for exactly one cycle, key_held=1, go to HELD.
- HELD state:
  - Column stays frozen and other keys are ignored (no rollover).
  - When row_s[r]==1, clear the counter and go to RELEASE.
- RELEASE state:
  - row_s[r]==1 increments the counter.
  - row_s[r]==0 returns to HELD with no new pulse (bounce on release).
  - At DEBOUNCE_CYCLES-1: key_held=0, c advances by 1, go to SCAN.
- key holds its value until the next accepted press.
- Counters: divider is $clog2(SCAN_DIV) bits; debounce counter is $clog2(DEBOUNCE_CYCLES) bits; no overflow is possible because each state exits at terminal count.
- Reset asserted mid-operation, in any state: all outputs return to reset values immediately (asynchronous); no key_valid is issued for the interrupted press.
- Minimum press-to-key_valid latency from the row edge: 2 (sync) + wait to the scan tick + DEBOUNCE_CYCLES + 1.

Optional Feature:
- Macro KEYPAD_TWO_DIGIT_EN.
- Defined: on each key_valid, digits <= {digits[3:0], new key}, so the newest key is in [3:0] and the previous key moves to [7:4].
- Undefined: digits is driven constant 8'h00; port list unchanged.

Decomposition:
- Package keypad_pkg:
  - enum state_t {SCAN, DEBOUNCE, HELD, RELEASE}
  - function keymap(row_idx, col_idx) returning logic [3:0]
  - constants COL_RESET=4'b1110, ROWS_IDLE=4'hF
- Sub-module sync_2ff (parameterized width, async active-high reset to all-ones) for the row synchronizer.
- FSM, divider and debounce counter live in keypad_scanner.

Test Plan:
Bench runs with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
- Reset, no keys -> col walks 1110, 1101, 1011, 0111, 1110 every 4 cycles; key=0, key_valid=0, key_held=0.
- Hold row=4'b1101 while col=4'b1101 (r1,c1) for 40 cycles -> exactly one key_valid pulse with key=4'h5; key_held=1; col frozen at 1101.
- 3-cycle glitch row=4'b0111 on col 0111 -> no key_valid; FSM returns to SCAN and col advances to 1110.
- Release '5', bounce low for 3 cycles inside RELEASE, then stay high 8+ cycles -> no second pulse; key_held falls once; scan resumes.
- Rows 0 and 2 low together on column 0 -> key=4'h1 (lowest row wins), single pulse. With KEYPAD_TWO_DIGIT_EN, following it with '5' gives digits=8'h15.
- Assert reset during DEBOUNCE -> outputs return to reset values the same cycle; col=4'b1110; no key_valid afterwards.
